// File: rtl/q2a03_bus_responder.sv
// q2a03_bus_responder
//
// Work-RAM target on the Q2A03 CPU bus. Each access starts on the rising edge
// of G_phy2. Address, direction and write data are captured on that edge, and
// the access is then served from a small RAM. The RAM is mirrored across the
// whole decode window by dropping the upper address bits. The block can stretch
// an access by holding G_ready low for WAIT_CYCLES clocks. When the address
// misses the window, G_rd_data is left untouched, so the bus keeps its last
// value (open bus).
//
// Parameters:
//   BASE         decode window base; an address hits when (G_addr & DECODE_MASK) == BASE
//   DECODE_MASK  address bits that take part in the decode
//   RAM_AW       RAM address width; the RAM holds 2^RAM_AW bytes
//   WAIT_CYCLES  clocks of G_ready low for each hit access (0..15)
//
// Ports:
//   G_clock    in   system clock, shared with the CPU
//   G_reset    in   asynchronous reset, active-low
//   G_phy2     in   CPU phase-2; its rising edge starts an access
//   G_addr     in   16-bit CPU address
//   G_rdwr     in   1 = read, 0 = write
//   G_wr_data  in   CPU write data
//   G_rd_data  out  registered read data (open bus on a miss)
//   G_ready    out  registered; 0 stalls the CPU
//   hit        out  registered; 1 while the current access targets this block

module q2a03_bus_responder #(
    parameter logic [15:0] BASE        = 16'h0000,
    parameter logic [15:0] DECODE_MASK = 16'hE000,
    parameter int          RAM_AW      = 11,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        G_clock,
    input  logic        G_reset,
    input  logic        G_phy2,
    input  logic [15:0] G_addr,
    input  logic        G_rdwr,
    input  logic [7:0]  G_wr_data,
    output logic [7:0]  G_rd_data,
    output logic        G_ready,
    output logic        hit
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // The wait counter is loaded with WAIT_CYCLES-1 because the clock that
    // leaves WAIT also counts as a stalled clock.
    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t              r_state;
    logic [3:0]          r_waitCnt;
    logic                r_phy2Q;
    logic [RAM_AW-1:0]   r_capAddr;
    logic                r_capRdwr;
    logic [7:0]          r_capWrData;
    logic [7:0]          r_mem [2**RAM_AW];

    logic                w_rise;
    logic                w_decode;
    logic [7:0]          w_ramRd;
    logic                w_ramWe;

    // Edge detector for phase 2. r_phy2Q resets to 0, so a G_phy2 that is
    // already high on the first clock after reset counts as a rise. This
    // matches the CPU's first bus cycle.
    assign w_rise   = G_phy2 & ~r_phy2Q;

    // Mirroring is plain truncation: only the low RAM_AW address bits are
    // kept, and the mask is responsible for every bit above them.
    assign w_decode = ((G_addr & DECODE_MASK) == BASE);
    assign w_ramRd  = r_mem[r_capAddr];
    assign w_ramWe  = (r_state == ACCESS) && !r_capRdwr;

    // Control FSM and registered bus outputs. Rises outside IDLE are ignored
    // and do not recapture; the CPU is frozen while G_ready is low, so a rise
    // there means the master broke the protocol. Once an access is committed
    // it completes even if G_phy2 falls early.
    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            r_state     <= IDLE;
            r_waitCnt   <= 4'd0;
            r_phy2Q     <= 1'b0;
            r_capAddr   <= '0;
            r_capRdwr   <= 1'b1;
            r_capWrData <= 8'h00;
            G_rd_data   <= 8'h00;
            G_ready     <= 1'b1;
            hit         <= 1'b0;
        end else begin
            r_phy2Q <= G_phy2;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_capAddr   <= G_addr[RAM_AW-1:0];
                        r_capRdwr   <= G_rdwr;
                        r_capWrData <= G_wr_data;
                        hit         <= w_decode;
                        if (w_decode) begin
                            if (WAIT_CYCLES > 0) begin
                                r_state   <= WAIT;
                                r_waitCnt <= WAIT_LOAD;
                                G_ready   <= 1'b0;
                            end else begin
                                r_state <= ACCESS;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (r_waitCnt == 4'd0) begin
                        r_state <= ACCESS;
                        G_ready <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end
                end
                ACCESS: begin
                    r_state <= IDLE;
                    // A write also drives its data onto the bus, as the real
                    // open bus would show it.
                    if (r_capRdwr) begin
                        G_rd_data <= w_ramRd;
                    end else begin
                        G_rd_data <= r_capWrData;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Work RAM. It has no reset, so its contents survive G_reset. Reset also
    // forces the FSM to IDLE, so a write that was still pending is dropped.
    always_ff @(posedge G_clock) begin
        if (w_ramWe) begin
            r_mem[r_capAddr] <= r_capWrData;
        end
    end

    // A new phase-2 rise must never arrive while an access is still in flight.
    assert property (@(posedge G_clock) disable iff (!G_reset)
                     !(w_rise && (r_state != IDLE)));

endmodule
